// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, keyboard command
// bytes and the frame parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INHIBIT   = 4'd1,
    ST_REQ       = 4'd2,
    ST_START     = 4'd3,
    ST_SHIFT     = 4'd4,
    ST_ACK       = 4'd5,
    ST_WAIT_IDLE = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } ps2_state_e;

  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_RESP_ACK    = 8'hFA;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 line: 2-flop synchroniser, FILTER_LEN-sample
// deglitcher and a one-cycle pulse on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser and filter state; idle PS/2 lines are pulled high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= {CW{1'b0}};
    end else begin
      sync1_q <= line_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new level is accepted only after FILTER_LEN consecutive differing samples.
  always_comb begin
    level_d = level_q;
    cnt_d   = {CW{1'b0}};
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
        cnt_d   = {CW{1'b0}};
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = {CW{1'b0}};
    end
    fall_d = level_q & ~level_d;
  end

  assign level = level_q;
  assign fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, requests to send, then
// shifts one command byte plus odd parity out on device clock falls.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12_000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] INH_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);

  ps2_state_e       state_q, state_d;
  logic [8:0]       shift_q, shift_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic clk_lvl_s, clk_fall_s, data_lvl_s, data_fall_unused;
  logic timeout_s;
  logic [3:0] bit_cnt_inc_s;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk     (clk),
    .rst_n   (clr),
    .line_in (ps2_clk_in),
    .level   (clk_lvl_s),
    .fall    (clk_fall_s)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk     (clk),
    .rst_n   (clr),
    .line_in (ps2_data_in),
    .level   (data_lvl_s),
    .fall    (data_fall_unused)
  );

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= ST_IDLE;
      shift_q   <= 9'd0;
      bit_cnt_q <= 4'd0;
      tmr_q     <= {TMR_W{1'b0}};
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign timeout_s     = (tmr_q == TMO_LAST);
  assign bit_cnt_inc_s = (bit_cnt_q == 4'hF) ? 4'hF : bit_cnt_q + 4'd1;

  // Next state and next line drive; the timer is both inhibit length and frame timeout.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = {TMR_W{1'b0}};
    clk_oe_d  = 1'b0;
    data_oe_d = data_oe_q;
    case (state_q)
      ST_IDLE: begin
        data_oe_d = 1'b0;
        bit_cnt_d = 4'd0;
        if (tx_valid) begin
          shift_d  = {odd_parity(tx_data), tx_data};
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (tmr_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_REQ;
        end else begin
          data_oe_d = 1'b0;
          tmr_d     = tmr_q + TMR_ONE;
        end
      end
      ST_REQ: begin
        data_oe_d = 1'b1;
        state_d   = ST_START;
      end
      ST_START: begin
        tmr_d = tmr_q + TMR_ONE;
        if (timeout_s) begin
          data_oe_d = 1'b0;
          state_d   = ST_ERR;
        end else if (clk_fall_s) begin
          data_oe_d = ~shift_q[0];
          shift_d   = {1'b0, shift_q[8:1]};
          bit_cnt_d = 4'd1;
          state_d   = ST_SHIFT;
        end else begin
          state_d = ST_START;
        end
      end
      ST_SHIFT: begin
        tmr_d = tmr_q + TMR_ONE;
        if (timeout_s) begin
          data_oe_d = 1'b0;
          state_d   = ST_ERR;
        end else if (clk_fall_s) begin
          bit_cnt_d = bit_cnt_inc_s;
          // Fall 10 releases data for the stop bit.
          if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
            state_d   = ST_ACK;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[8:1]};
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_ACK: begin
        tmr_d     = tmr_q + TMR_ONE;
        data_oe_d = 1'b0;
        if (timeout_s) begin
          state_d = ST_ERR;
        end else if (clk_fall_s) begin
          bit_cnt_d = bit_cnt_inc_s;
          state_d   = data_lvl_s ? ST_ERR : ST_WAIT_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        tmr_d     = tmr_q + TMR_ONE;
        data_oe_d = 1'b0;
        if (timeout_s) begin
          state_d = ST_ERR;
        end else if (clk_lvl_s && data_lvl_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT_IDLE;
        end
      end
      ST_DONE, ST_ERR: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: begin
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    done_d  = (state_d == ST_DONE);
    err_d   = (state_d == ST_ERR);
    ready_d = (state_d == ST_IDLE);
    busy_d  = !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule
